result_bcd_converter: RTL and testbench

//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/result_bcd_converter.sv | 80 ++++++++
 tb/tb_result_bcd_converter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// A start/busy/done handshake lets the top level re-convert whenever the result changes.
module result_bcd_converter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]   r_scratch;
  logic            r_ovf;
  logic [CW-1:0]   r_count;
  logic [BW-1:0]   w_adj;

  // Each digit is corrected independently; no carry propagates between digits.
  always_comb begin
    w_adj = r_scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_ovf     <= 1'b0;
      r_count   <= '0;
      done      <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= bin_in;
            r_scratch <= '0;
            r_ovf     <= 1'b0;
            r_count   <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {r_scratch, r_shift} <= {w_adj[BW-2:0], r_shift, 1'b0};
          r_ovf   <= r_ovf | w_adj[BW-1];
          r_count <= r_count + CW'(1);
          if (r_count == CW'(WIDTH - 1))
            r_state <= S_DONE;
        end
        S_DONE: begin
          bcd_out  <= r_scratch;
          overflow <= r_ovf;
          done     <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter: a 3-digit instance and a 2-digit
// instance that exercises truncation and the overflow flag.
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start3 = 1'b0, start2 = 1'b0;
  logic [7:0]  bin3 = '0, bin2 = '0;
  logic        busy3, done3, ovf3;
  logic        busy2, done2, ovf2;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  result_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut3 (
    .clk(clk), .resetn(resetn), .start(start3), .bin_in(bin3),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3));

  result_bcd_converter #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .bin_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one conversion and check latency, busy width, result and done width.
  task automatic convert(input bit two, input logic [7:0] v, input logic [11:0] exp_bcd,
                         input logic exp_ovf, input string tag);
    int cycles;
    int busy_cnt;
    if (two) begin start2 = 1'b1; bin2 = v; end
    else     begin start3 = 1'b1; bin3 = v; end
    tick();
    start2 = 1'b0;
    start3 = 1'b0;
    cycles = 0;
    busy_cnt = 0;
    while (!(two ? done2 : done3) && cycles < 30) begin
      if (two ? busy2 : busy3) busy_cnt++;
      tick();
      cycles++;
    end
    chk({tag, "_lat"}, cycles, 9);
    chk({tag, "_busy"}, busy_cnt, 9);
    chk({tag, "_bcd"}, two ? {4'h0, bcd2} : bcd3, exp_bcd);
    chk({tag, "_ovf"}, two ? ovf2 : ovf3, exp_ovf);
    tick();
    chk({tag, "_done_drop"}, two ? done2 : done3, 1'b0);
  endtask

  initial begin
    int cyc, last, ndone;
    tick();
    tick();
    chk("rst_busy", busy3, 1'b0);
    chk("rst_done", done3, 1'b0);
    chk("rst_bcd", bcd3, 12'h000);
    chk("rst_ovf", ovf3, 1'b0);
    resetn = 1'b1;
    tick();

    convert(1'b0, 8'd0,   12'h000, 1'b0, "c0");
    convert(1'b0, 8'd255, 12'h255, 1'b0, "c255");
    convert(1'b0, 8'd99,  12'h099, 1'b0, "c99");
    convert(1'b0, 8'd100, 12'h100, 1'b0, "c100");

    // Held start: conversions back to back every 10 cycles.
    start3 = 1'b1;
    bin3 = 8'd42;
    cyc = 0; last = 0; ndone = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      cyc++;
      if (done3) begin
        ndone++;
        chk("rep_gap", cyc - last, 10);
        chk("rep_bcd", bcd3, 12'h042);
        last = cyc;
      end
    end
    chk("rep_count", ndone, 3);
    start3 = 1'b0;
    for (int i = 0; i < 12 && busy3; i++) tick();
    tick();
    chk("rep_idle", busy3, 1'b0);

    // Start while busy is ignored; bin_in is only sampled at the start edge.
    start3 = 1'b1;
    bin3 = 8'd17;
    tick();
    start3 = 1'b0;
    tick();
    tick();
    bin3 = 8'd200;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    cyc = 0;
    while (!done3 && cyc < 30) begin tick(); cyc++; end
    chk("ign_lat", cyc + 3, 9);
    chk("ign_bcd", bcd3, 12'h017);
    tick();
    chk("ign_busy", busy3, 1'b0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (done3) ndone++; end
    chk("ign_nodone", ndone, 0);

    // Reset mid-conversion aborts and clears the result.
    start3 = 1'b1;
    bin3 = 8'd123;
    tick();
    start3 = 1'b0;
    tick(); tick(); tick(); tick();
    resetn = 1'b0;
    tick();
    chk("abort_busy", busy3, 1'b0);
    chk("abort_done", done3, 1'b0);
    chk("abort_bcd", bcd3, 12'h000);
    resetn = 1'b1;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (done3) ndone++; end
    chk("abort_nodone", ndone, 0);

    convert(1'b1, 8'd200, 12'h000, 1'b1, "d2_200");
    convert(1'b1, 8'd57,  12'h057, 1'b0, "d2_57");
    convert(1'b1, 8'd99,  12'h099, 1'b0, "d2_99");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
